// File: rtl/frame_timing_monitor.sv
// Frame timing monitor: measures line and frame timing from a DE stream and flags deviations.
// Define FTM_SEQ_CHECK_EN to check decoded frame modes against the frameRate/frameNum sequence.
module frame_timing_monitor #(
    parameter int unsigned HTOTAL = 520,
    parameter int unsigned HRES   = 480,
    parameter int unsigned VRES   = 1080
) (
    input  logic        clkout,
    input  logic        Reset,
    input  logic        de_in,
    input  logic        clear,
    input  logic [31:0] frameRate,
    input  logic [2:0]  frameNum,
    output logic        frame_done,
    output logic [12:0] last_vtotal,
    output logic [11:0] last_active,
    output logic [3:0]  last_mode,
    output logic [15:0] frame_cnt,
    output logic        hres_err,
    output logic        vres_err,
    output logic        no_signal,
    output logic        seq_err
);
    localparam int unsigned LT_W  = 13;
    localparam int unsigned ACT_W = 12;
    localparam int unsigned BLK_W = 13;
    localparam int unsigned HC_W  = 16;
    localparam int unsigned FC_W  = 16;
    localparam int unsigned MD_W  = 4;
    // One tick short of saturation: the next blank tick makes 8191 blank lines.
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(8190);

    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

    state_t             state;
    logic               de_d;
    logic               seen_tick;
    logic [LT_W-1:0]    lt;
    logic [ACT_W-1:0]   active_cnt;
    logic [BLK_W-1:0]   blank_cnt;
    logic [HC_W-1:0]    hcnt;

    logic               rise_c;
    logic               fall_c;
    logic               tick_c;
    logic               boundary_c;
    logic               leave_idle_c;
    logic               hres_set_c;
    logic               vres_set_c;
    logic [BLK_W-1:0]   vtotal_c;
    logic [MD_W-1:0]    mode_c;

    function automatic logic [MD_W-1:0] decode_mode(input logic [BLK_W-1:0] vt);
        case (vt)
            13'd5280: decode_mode = 4'd0;
            13'd2640: decode_mode = 4'd1;
            13'd1760: decode_mode = 4'd2;
            13'd1320: decode_mode = 4'd3;
            13'd1100: decode_mode = 4'd4;
            default:  decode_mode = 4'd15;
        endcase
    endfunction

    assign rise_c       = de_in & ~de_d;
    assign fall_c       = ~de_in & de_d;
    assign tick_c       = ~rise_c & (lt == LT_W'(HTOTAL));
    assign boundary_c   = (state == BLANK) & rise_c;
    assign leave_idle_c = (state == IDLE) & rise_c & seen_tick;
    assign hres_set_c   = fall_c & (hcnt != HC_W'(HRES));
    assign vres_set_c   = boundary_c & (active_cnt != ACT_W'(VRES));
    assign vtotal_c     = BLK_W'(active_cnt) + blank_cnt;
    assign mode_c       = decode_mode(vtotal_c);

    // Line timer, line-length check, frame state machine and result latching
    always_ff @(posedge clkout) begin
        if (!Reset) begin
            state       <= IDLE;
            no_signal   <= 1'b1;
            de_d        <= 1'b0;
            seen_tick   <= 1'b0;
            lt          <= '0;
            active_cnt  <= '0;
            blank_cnt   <= '0;
            hcnt        <= '0;
            frame_done  <= 1'b0;
            last_vtotal <= '0;
            last_active <= '0;
            last_mode   <= '0;
            frame_cnt   <= '0;
            hres_err    <= 1'b0;
            vres_err    <= 1'b0;
        end else begin
            de_d       <= de_in;
            frame_done <= 1'b0;

            if (rise_c || (lt == LT_W'(HTOTAL))) begin
                lt <= LT_W'(1);
            end else begin
                lt <= lt + LT_W'(1);
            end

            if (de_in) begin
                hcnt <= rise_c ? HC_W'(1) : hcnt + HC_W'(1);
            end

            // A new error or a frame increment in the clear cycle wins over clear
            if (clear) begin
                hres_err <= 1'b0;
                vres_err <= 1'b0;
            end
            if (hres_set_c) hres_err <= 1'b1;
            if (vres_set_c) vres_err <= 1'b1;

            if (boundary_c) begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end else if (clear) begin
                frame_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (leave_idle_c) begin
                        state      <= ACTIVE;
                        no_signal  <= 1'b0;
                        seen_tick  <= 1'b0;
                        active_cnt <= ACT_W'(1);
                        blank_cnt  <= '0;
                    end else if (tick_c) begin
                        seen_tick <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (rise_c) begin
                        active_cnt <= active_cnt + ACT_W'(1);
                    end else if (tick_c) begin
                        state     <= BLANK;
                        blank_cnt <= BLK_W'(1);
                    end
                end
                BLANK: begin
                    if (boundary_c) begin
                        last_active <= active_cnt;
                        last_vtotal <= vtotal_c;
                        last_mode   <= mode_c;
                        frame_done  <= 1'b1;
                        active_cnt  <= ACT_W'(1);
                        blank_cnt   <= '0;
                        state       <= ACTIVE;
                    end else if (tick_c) begin
                        if (blank_cnt == BLK_LAST) begin
                            state      <= IDLE;
                            no_signal  <= 1'b1;
                            seen_tick  <= 1'b0;
                            active_cnt <= '0;
                            blank_cnt  <= '0;
                        end else begin
                            blank_cnt <= blank_cnt + BLK_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FTM_SEQ_CHECK_EN
    logic [2:0]      idx;
    logic [2:0]      idx_last_c;
    logic [MD_W-1:0] slot_c;

    assign idx_last_c = (frameNum == 3'd0) ? 3'd0 : frameNum - 3'd1;
    assign slot_c     = frameRate[{idx, 2'b00} +: 4];

    // Sequence index restarts with the first frame after leaving IDLE
    always_ff @(posedge clkout) begin
        if (!Reset) begin
            idx     <= '0;
            seq_err <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (leave_idle_c) begin
                idx <= '0;
            end else if (boundary_c) begin
                seq_err <= (mode_c != slot_c);
                idx     <= (idx >= idx_last_c) ? 3'd0 : idx + 3'd1;
            end
        end
    end
`else
    logic seq_unused_c;
    assign seq_unused_c = ^{frameRate, frameNum};

    always_ff @(posedge clkout) begin
        seq_err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_frame_timing_monitor.sv
// Directed bench for frame_timing_monitor with a scaled-down line length and a frame scoreboard.
module tb_frame_timing_monitor;
    localparam int unsigned HT = 3;
    localparam int unsigned HR = 2;
    localparam int unsigned VR = 1080;
`ifdef FTM_SEQ_CHECK_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    logic        clkout;
    logic        Reset;
    logic        de_in;
    logic        clear;
    logic [31:0] frameRate;
    logic [2:0]  frameNum;
    logic        frame_done;
    logic [12:0] last_vtotal;
    logic [11:0] last_active;
    logic [3:0]  last_mode;
    logic [15:0] frame_cnt;
    logic        hres_err;
    logic        vres_err;
    logic        no_signal;
    logic        seq_err;

    frame_timing_monitor #(.HTOTAL(HT), .HRES(HR), .VRES(VR)) dut (
        .clkout(clkout), .Reset(Reset), .de_in(de_in), .clear(clear),
        .frameRate(frameRate), .frameNum(frameNum), .frame_done(frame_done),
        .last_vtotal(last_vtotal), .last_active(last_active), .last_mode(last_mode),
        .frame_cnt(frame_cnt), .hres_err(hres_err), .vres_err(vres_err),
        .no_signal(no_signal), .seq_err(seq_err)
    );

    typedef struct {
        int vtotal;
        int active;
        int mode;
        int cnt;
        bit seq;
        int gap;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    exp_t got;
    bit   pend_valid = 1'b0;
    bit   done_valid = 1'b0;
    int   cnt_m = 0;
    int   idx_m = 0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_done = 0;

    initial begin
        clkout = 1'b0;
        forever #5 clkout = ~clkout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clkout);
        #1;
    endtask

    task automatic blank_clocks(input int n);
        de_in = 1'b0;
        repeat (n) clk1();
    endtask

    // Each line is HT clocks; DE is high HR clocks, or HR-1 on the bad line
    task automatic active_lines(input int n, input int bad);
        for (int l = 0; l < n; l++) begin
            for (int c = 0; c < int'(HT); c++) begin
                de_in = (c < ((l == bad) ? int'(HR) - 1 : int'(HR)));
                clk1();
            end
        end
    endtask

    // Called just before a frame's first rise; that rise closes the pending frame
    task automatic open_frame(input int act, input int blk, input int mode);
        exp_t e;
        if (pend_valid) begin
            e = pend;
            cnt_m = (cnt_m + 1) % 65536;
            e.cnt = cnt_m;
            e.seq = SEQ_ON && (pend.mode != int'((frameRate >> (4 * idx_m)) & 32'hF));
            idx_m = (idx_m >= ((frameNum == 3'd0) ? 0 : int'(frameNum) - 1)) ? 0 : idx_m + 1;
            e.gap = done_valid ? pend.vtotal * int'(HT) : 0;
            done_valid = 1'b1;
            sb.push_back(e);
        end else begin
            idx_m = 0;
            done_valid = 1'b0;
        end
        pend.vtotal = act + blk;
        pend.active = act;
        pend.mode   = mode;
        pend.cnt    = 0;
        pend.seq    = 1'b0;
        pend.gap    = 0;
        pend_valid  = 1'b1;
    endtask

    task automatic run_frame(input int act, input int blk, input int mode);
        open_frame(act, blk, mode);
        active_lines(act, -1);
        blank_clocks(blk * int'(HT));
    endtask

    // Scoreboard: every frame_done pops one expected frame result
    always @(negedge clkout) begin
        cyc++;
        if (frame_done) begin
            if (sb.size() == 0) begin
                chk("spurious_frame_done", 32'(frame_done), 32'd0);
            end else begin
                got = sb.pop_front();
                chk("last_vtotal", 32'(last_vtotal), 32'(got.vtotal));
                chk("last_active", 32'(last_active), 32'(got.active));
                chk("last_mode", 32'(last_mode), 32'(got.mode));
                chk("frame_cnt_at_done", 32'(frame_cnt), 32'(got.cnt));
                chk("seq_err_at_done", 32'(seq_err), 32'(got.seq));
                if (got.gap != 0) chk("frame_period", 32'(cyc - last_done), 32'(got.gap));
            end
            last_done = cyc;
        end else begin
            chk("seq_err_between_frames", 32'(seq_err), 32'd0);
        end
    end

    initial begin
        Reset     = 1'b0;
        de_in     = 1'b0;
        clear     = 1'b0;
        frameRate = 32'h0000_0041;
        frameNum  = 3'd2;
        repeat (3) clk1();
        chk("rst_no_signal", 32'(no_signal), 32'd1);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_last_vtotal", 32'(last_vtotal), 32'd0);
        chk("rst_last_active", 32'(last_active), 32'd0);
        chk("rst_last_mode", 32'(last_mode), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_hres_err", 32'(hres_err), 32'd0);
        chk("rst_vres_err", 32'(vres_err), 32'd0);

        Reset = 1'b1;
        blank_clocks(3 * int'(HT));

        // Nominal 1100-line frame, then a 2640-line frame
        open_frame(1080, 20, 4);
        active_lines(1080, -1);
        chk("no_signal_after_entry", 32'(no_signal), 32'd0);
        blank_clocks(20 * int'(HT));
        run_frame(1080, 1560, 1);

        // Frame with one short-DE line; clear during its blanking
        open_frame(1080, 20, 4);
        active_lines(1080, 5);
        chk("hres_err_sticky", 32'(hres_err), 32'd1);
        chk("vres_err_nominal", 32'(vres_err), 32'd0);
        chk("frame_cnt_before_clear", 32'(frame_cnt), 32'd2);
        clear = 1'b1;
        blank_clocks(1);
        clear = 1'b0;
        cnt_m = 0;
        blank_clocks(20 * int'(HT) - 1);
        chk("hres_err_cleared", 32'(hres_err), 32'd0);
        chk("frame_cnt_cleared", 32'(frame_cnt), 32'd0);

        // Short frame: 1079 active lines
        run_frame(1079, 21, 4);
        chk("vres_err_before_close", 32'(vres_err), 32'd0);
        open_frame(1, 0, 0);
        active_lines(1, -1);
        chk("vres_err_short_frame", 32'(vres_err), 32'd1);
        chk("last_active_short", 32'(last_active), 32'd1079);
        chk("hres_err_still_clear", 32'(hres_err), 32'd0);

        // Signal loss: 8191 blank lines drop to IDLE, partial frame discarded
        blank_clocks(8190 * int'(HT));
        chk("no_signal_at_8190", 32'(no_signal), 32'd0);
        blank_clocks(5 * int'(HT));
        chk("no_signal_after_8191", 32'(no_signal), 32'd1);
        pend_valid = 1'b0;

        // Recovery and mode sequence 2640, 1100, 2640, 2640, then an odd 50-line frame
        open_frame(1080, 1560, 1);
        active_lines(1080, -1);
        chk("no_signal_recovered", 32'(no_signal), 32'd0);
        blank_clocks(1560 * int'(HT));
        run_frame(1080, 20, 4);
        run_frame(1080, 1560, 1);
        run_frame(1080, 1560, 1);
        run_frame(10, 40, 15);
        open_frame(1080, 20, 4);
        active_lines(50, -1);
        chk("all_frames_seen", 32'(sb.size()), 32'd0);
        chk("frame_cnt_final", 32'(frame_cnt), 32'(cnt_m));

        // Reset mid-frame abandons the frame
        Reset = 1'b0;
        de_in = 1'b0;
        pend_valid = 1'b0;
        repeat (3) clk1();
        chk("midrst_no_signal", 32'(no_signal), 32'd1);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("midrst_last_vtotal", 32'(last_vtotal), 32'd0);
        chk("midrst_last_mode", 32'(last_mode), 32'd0);
        chk("midrst_vres_err", 32'(vres_err), 32'd0);
        Reset = 1'b1;
        blank_clocks(6);
        chk("post_rst_idle", 32'(no_signal), 32'd1);
        chk("post_rst_no_frames", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
